// File: rtl/sram_host_pkg.sv
// Shared definitions for the SRAM host controller: FSM states and default widths.
package sram_host_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    TURN
  } state_e;

endpackage

// File: rtl/sram_bus_io.sv
// Tri-state driver for the shared SRAM data bus; keeps the inout at one place in the hierarchy.
module sram_bus_io #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  drive_en,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] in_data,
  inout  wire  [DATA_WIDTH-1:0] bus
);

  assign bus     = drive_en ? out_data : {DATA_WIDTH{1'bz}};
  assign in_data = bus;

endmodule

// File: rtl/sram_host_ctrl.sv
// Host-side SRAM controller: valid/ready requests in, registered SRAM pin activity out,
// with a one-cycle turnaround between a read and a following write.
module sram_host_ctrl
  import sram_host_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  state_e                state;
  state_e                state_nxt;
  logic                  accept;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_sample;

  assign req_ready = (state == IDLE) || (state == WR) || (state == RD_DATA);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WR: begin
        if (accept) state_nxt = req_we ? WR : RD_ADDR;
        else        state_nxt = IDLE;
      end
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: begin
        if (accept) state_nxt = req_we ? TURN : RD_ADDR;
        else        state_nxt = IDLE;
      end
      TURN:    state_nxt = WR;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin controls are decoded from the next state so they are registered with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      drive_en  <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_cs    <= state_nxt inside {WR, RD_ADDR, RD_DATA};
      mem_we    <= (state_nxt == WR);
      mem_oe    <= state_nxt inside {RD_ADDR, RD_DATA};
      drive_en  <= (state_nxt == WR);
      rsp_valid <= (state == RD_DATA);
      if (accept)            mem_addr  <= req_addr;
      if (state == RD_DATA)  rsp_rdata <= rd_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req_wdata;
  end

  sram_bus_io #(.DATA_WIDTH(DATA_WIDTH)) u_bus_io (
    .drive_en (drive_en),
    .out_data (wdata_q),
    .in_data  (rd_sample),
    .bus      (mem_data)
  );

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: SRAM model on the bus, directed scenarios, then random traffic
// checked against a transaction-level reference (memory array + expected-response queue).
module tb_sram_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [7:0] mem_addr;
  wire  [7:0] mem_data;
  logic       mem_cs;
  logic       mem_we;
  logic       mem_oe;

  always #5 clk = ~clk;

  sram_host_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe)
  );

  // Synchronous SRAM: writes at the edge ending a write cycle, output register loads on read cycles.
  logic [7:0] sram [256];
  logic [7:0] sram_q;
  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_data;
    if (mem_cs && mem_oe && !mem_we) sram_q <= sram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? sram_q : 8'bz;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] rsp_q [$];
  logic [3:1] rd_hist = '0;   // bit k: a read was accepted k cycles ago
  logic       wr1 = 1'b0;     // a write was accepted last cycle
  logic       exp_ready = 1'b1;
  logic       acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    exp_ready = !rd_hist[1] && !(wr1 && rd_hist[3]);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, rd_hist[3]);
    if (rd_hist[3]) begin
      if (rsp_q.size() > 0) chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
      else begin
        errors++;
        $error("FAIL rsp_queue observed=empty expected=pending read");
      end
    end
    chk("contention", dut.drive_en && mem_cs && mem_oe && !mem_we, 0);
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a,
                       input logic [7:0] d, output logic accepted);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    accepted  = v && exp_ready;
    if (accepted && !we) rsp_q.push_back(ref_mem[a]);
    if (accepted && we)  ref_mem[a] = d;
    rd_hist = {rd_hist[2:1], accepted && !we};
    wr1     = accepted && we;
  endtask

  task automatic req(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    logic ok;
    do begin
      tick();
      drive(1'b1, we, a, d, ok);
      n++;
    end while (!ok && n < 8);
    if (!ok) begin
      errors++;
      $error("FAIL req_accept observed=not accepted expected=accepted within 8 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    end
  endtask

  task automatic clear_model();
    rd_hist   = '0;
    wr1       = 1'b0;
    exp_ready = 1'b1;
    rsp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"}, mem_cs, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_oe"}, mem_oe, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_drive"}, dut.drive_en, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset with random request activity
    repeat (3) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
    end
    #1 check_reset_outputs("reset");
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    rst_n = 1'b1;

    // Write 0xA5 to 0x10 then read it back
    req(1'b1, 8'h10, 8'hA5);
    tick();
    chk("wr_cs", mem_cs, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_oe", mem_oe, 0);
    chk("wr_addr", mem_addr, 8'h10);
    chk("wr_bus", mem_data, 8'hA5);
    chk("wr_busy", busy, 1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    req(1'b0, 8'h10, 8'h00);
    tick();
    chk("rda_oe", mem_oe, 1);
    chk("rda_we", mem_we, 0);
    chk("rda_drive", dut.drive_en, 0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    idle(1);
    tick();
    chk("rd_lat_valid", rsp_valid, 1);
    chk("rd_lat_data", rsp_rdata, 8'hA5);
    chk("sram_10", sram[8'h10], 8'hA5);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    idle(2);

    // Back-to-back writes, then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i > 0) chk("burst_wr_active", mem_cs && mem_we, 1);
      chk("burst_ready", req_ready, 1);
      drive(1'b1, 1'b1, 8'(i), 8'((i + 1) * 8'h11), acc);
    end
    idle(2);
    for (int i = 0; i < 4; i++) chk("burst_sram", sram[i], (i + 1) * 8'h11);
    for (int i = 0; i < 4; i++) req(1'b0, 8'(i), 8'h00);
    idle(5);

    // Read followed immediately by a write to the same address
    req(1'b1, 8'hFF, 8'h3C);
    req(1'b0, 8'hFF, 8'h00);
    req(1'b1, 8'hFF, 8'h5A);
    tick();
    chk("turn_cs", mem_cs, 0);
    chk("turn_oe", mem_oe, 0);
    chk("turn_drive", dut.drive_en, 0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    tick();
    chk("turn_wr_we", mem_we, 1);
    chk("turn_wr_bus", mem_data, 8'h5A);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    idle(1);
    chk("sram_ff", sram[8'hFF], 8'h5A);
    req(1'b0, 8'hFF, 8'h00);
    idle(5);

    // Reset asserted during the address phase of a read
    req(1'b0, 8'h10, 8'h00);
    tick();
    chk("pre_rst_oe", mem_oe, 1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    clear_model();
    repeat (2) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, acc);
    clear_model();
    rst_n = 1'b1;
    idle(6);

    // Random traffic over a small address window
    for (int i = 0; i < 16; i++) req(1'b1, 8'(8'hC0 + i), 8'($urandom));
    for (int i = 0; i < 400; i++) begin
      tick();
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            8'(8'hC0 + $urandom_range(0, 15)), 8'($urandom), acc);
    end
    idle(6);
    chk("rsp_drain", rsp_q.size(), 0);
    for (int i = 0; i < 16; i++) chk("rand_sram", sram[8'hC0 + i], ref_mem[8'hC0 + i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
